// File: rtl/addsub_pipe.sv
// ---------------------------------------------------------------------------
// addsub_pipe
//
// Pipelined WIDTH-bit adder/subtractor. The add is cut into STAGES chunks of
// CHUNK = WIDTH/STAGES bits. Each chunk is resolved in its own pipeline stage
// using the carry registered by the stage before it, so the critical path is
// one CHUNK-bit add rather than a full WIDTH-bit ripple.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset; clears all stages and outputs
//   in_valid   operand bundle valid
//   in_ready   bundle accepted this cycle (= !out_valid || out_ready)
//   A, B       operands
//   SUB        0: A+B, 1: A-B (computed as A + ~B + 1)
//   SAT        1: clamp the result on signed overflow
//   out_valid  result valid
//   out_ready  consumer accepts the result
//   ans        result (saturated when SAT && V)
//   cout       carry out of bit WIDTH-1 (on subtract, 1 = no borrow)
//   V          raw signed overflow flag, independent of SAT
//
// Latency is STAGES cycles with no stall; one result per cycle at full rate.
// The whole pipeline advances or holds as a unit, so bubbles stay in place
// while the output is stalled.
// ---------------------------------------------------------------------------
module addsub_pipe #(
    parameter int unsigned WIDTH  = 32,
    parameter int unsigned STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             SUB,
    input  logic             SAT,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ans,
    output logic             cout,
    output logic             V
);

    localparam int unsigned CHUNK = WIDTH / STAGES;
    localparam int unsigned LAST  = STAGES - 1;

    if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
        $error("addsub_pipe: WIDTH must be >= 2 and divisible by STAGES");
    end

    // Whole-pipeline advance: the output slot is free or being drained.
    logic w_advance;
    assign w_advance = !out_valid || out_ready;
    assign in_ready  = w_advance;

    // Per-stage inputs. Operands are kept right-aligned: the chunk a stage
    // works on always sits in bits [CHUNK-1:0], and unconsumed upper chunks
    // shift down by CHUNK each stage. Partial sums are kept at their final
    // bit positions so the result needs no realignment at the end.
    logic [WIDTH-1:0] w_a_in   [STAGES];
    logic [WIDTH-1:0] w_b_in   [STAGES];
    logic [WIDTH-1:0] w_s_in   [STAGES];
    logic             w_c_in   [STAGES];
    logic             w_sat_in [STAGES];
    logic             w_vld_in [STAGES];

    assign w_a_in[0]   = A;
    assign w_b_in[0]   = SUB ? ~B : B;
    assign w_s_in[0]   = '0;
    assign w_c_in[0]   = SUB;
    assign w_sat_in[0] = SAT;
    assign w_vld_in[0] = in_valid;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic [CHUNK-1:0] w_chunk;
        logic             w_co;
        logic [WIDTH-1:0] w_sum;

        always_comb begin
            {w_co, w_chunk} = {1'b0, w_a_in[k][CHUNK-1:0]}
                            + {1'b0, w_b_in[k][CHUNK-1:0]}
                            + {{CHUNK{1'b0}}, w_c_in[k]};
            w_sum = w_s_in[k];
            w_sum[k*CHUNK +: CHUNK] = w_chunk;
        end

        if (k < LAST) begin : g_mid
            logic             r_vld;
            logic             r_c;
            logic             r_sat;
            logic [WIDTH-1:0] r_a;
            logic [WIDTH-1:0] r_b;
            logic [WIDTH-1:0] r_s;

            // Data only loads with a valid bundle so idle-cycle operand
            // garbage never enters the datapath.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld <= 1'b0;
                    r_c   <= 1'b0;
                    r_sat <= 1'b0;
                    r_a   <= '0;
                    r_b   <= '0;
                    r_s   <= '0;
                end else if (w_advance) begin
                    r_vld <= w_vld_in[k];
                    if (w_vld_in[k]) begin
                        r_c   <= w_co;
                        r_sat <= w_sat_in[k];
                        r_a   <= w_a_in[k] >> CHUNK;
                        r_b   <= w_b_in[k] >> CHUNK;
                        r_s   <= w_sum;
                    end
                end
            end

            assign w_a_in[k+1]   = r_a;
            assign w_b_in[k+1]   = r_b;
            assign w_s_in[k+1]   = r_s;
            assign w_c_in[k+1]   = r_c;
            assign w_sat_in[k+1] = r_sat;
            assign w_vld_in[k+1] = r_vld;
        end else begin : g_last
            logic             w_cmsb;
            logic             w_v;
            logic [WIDTH-1:0] w_res;

            logic             r_vld;
            logic [WIDTH-1:0] r_ans;
            logic             r_cout;
            logic             r_v;

            // Carry into the MSB is recovered from the MSB sum bit:
            // s = a ^ b ^ cin  =>  cin = a ^ b ^ s.
            always_comb begin
                w_cmsb = w_a_in[k][CHUNK-1] ^ w_b_in[k][CHUNK-1] ^ w_chunk[CHUNK-1];
                w_v    = w_cmsb ^ w_co;
                w_res  = w_sum;
                if (w_sat_in[k] && w_v) begin
                    w_res = w_a_in[k][CHUNK-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                               : {1'b0, {(WIDTH-1){1'b1}}};
                end
            end

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vld  <= 1'b0;
                    r_ans  <= '0;
                    r_cout <= 1'b0;
                    r_v    <= 1'b0;
                end else if (w_advance) begin
                    r_vld <= w_vld_in[k];
                    if (w_vld_in[k]) begin
                        r_ans  <= w_res;
                        r_cout <= w_co;
                        r_v    <= w_v;
                    end
                end
            end

            assign out_valid = r_vld;
            assign ans       = r_ans;
            assign cout      = r_cout;
            assign V         = r_v;
        end
    end

endmodule

// File: tb/tb_addsub_pipe.sv
module tb_addsub_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] A;
    logic [31:0] B;
    logic        SUB;
    logic        SAT;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] ans;
    logic        cout;
    logic        V;

    int errors = 0;
    int checks = 0;

    // Expected {ans, cout, V}, oldest first.
    logic [33:0] sb[$];

    logic        hold_prev = 1'b0;
    logic [31:0] p_ans;
    logic        p_cout;
    logic        p_v;

    always #5 clk = ~clk;

    addsub_pipe #(.WIDTH(32), .STAGES(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .SUB       (SUB),
        .SAT       (SAT),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .ans       (ans),
        .cout      (cout),
        .V         (V)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: overflow from operand/result signs, not from carries.
    function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic sub, input logic sat);
        logic [32:0] s;
        logic [31:0] bb;
        logic [31:0] r;
        logic        v;
        bb = sub ? ~b : b;
        s  = {1'b0, a} + {1'b0, bb} + {32'd0, sub};
        v  = (a[31] == bb[31]) && (s[31] != a[31]);
        r  = s[31:0];
        if (sat && v) r = a[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {r, s[32], v};
    endfunction

    // Output monitor / scoreboard pop, sampled on the falling edge.
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                chk("hold_valid", {63'd0, out_valid}, 64'd1);
                chk("hold_ans",   {32'd0, ans},       {32'd0, p_ans});
                chk("hold_cout",  {63'd0, cout},      {63'd0, p_cout});
                chk("hold_v",     {63'd0, V},         {63'd0, p_v});
            end
            if (out_valid && out_ready) begin
                checks++;
                assert (sb.size() > 0) else begin
                    errors++;
                    $error("FAIL spurious_out: observed result ans=%0h with empty scoreboard, required none", ans);
                end
                if (sb.size() > 0) begin
                    logic [33:0] e;
                    e = sb.pop_front();
                    chk("ans",  {32'd0, ans},  {32'd0, e[33:2]});
                    chk("cout", {63'd0, cout}, {63'd0, e[1]});
                    chk("V",    {63'd0, V},    {63'd0, e[0]});
                end
            end
            hold_prev = out_valid && !out_ready;
            p_ans     = ans;
            p_cout    = cout;
            p_v       = V;
        end
    end

    // Present one bundle and wait for it to be accepted.
    task automatic send(input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic sat, input logic [33:0] exp);
        int n = 0;
        A = a; B = b; SUB = sub; SAT = sat; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("send_accept", {63'd0, in_ready}, 64'd1);
        sb.push_back(exp);
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while ((sb.size() != 0 || out_valid) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain_empty", 64'(sb.size()), 64'd0);
        chk("drain_idle",  {63'd0, out_valid}, 64'd0);
    endtask

    initial begin
        int lat;
        int sent;

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        A = '0; B = '0; SUB = 1'b0; SAT = 1'b0;
        #1;
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_ans",       {32'd0, ans},       64'd0);
        chk("rst_cout",      {63'd0, cout},      64'd0);
        chk("rst_v",         {63'd0, V},         64'd0);
        chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
        #11 rst_n = 1'b1;
        @(posedge clk); #1;

        // Latency of a single add.
        A = 32'h1; B = 32'h2; SUB = 1'b0; SAT = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        chk("lat_in_ready", {63'd0, in_ready}, 64'd1);
        sb.push_back({32'h0000_0003, 1'b0, 1'b0});
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("latency", 64'(lat), 64'd4);
        drain();

        // Directed arithmetic cases, back to back.
        send(32'h0000_0000, 32'h0000_0001, 1'b1, 1'b0, {32'hFFFF_FFFF, 1'b0, 1'b0});
        send(32'h0000_0005, 32'h0000_0003, 1'b1, 1'b0, {32'h0000_0002, 1'b1, 1'b0});
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h8000_0000, 1'b0, 1'b1});
        send(32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, {32'h7FFF_FFFF, 1'b0, 1'b1});
        send(32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, {32'h8000_0000, 1'b1, 1'b1});
        send(32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0100_0000, 1'b0, 1'b0});
        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_0000, 1'b1, 1'b0});
        drain();

        // 8 back-to-back bundles, out_ready low for cycles 5..7.
        sent = 0;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            out_ready = !(c >= 5 && c < 8);
            in_valid  = 1'b1;
            A   = 32'h0101_0101 * (sent + 1);
            B   = 32'h00FF_00FF + 32'(sent);
            SUB = sent[0];
            SAT = 1'b0;
            @(negedge clk);
            if (c >= 5 && c < 8) chk("stall_in_ready", {63'd0, in_ready}, 64'd0);
            else                 chk("flow_in_ready",  {63'd0, in_ready}, 64'd1);
            if (in_ready) begin
                sb.push_back(model(A, B, SUB, SAT));
                sent++;
            end
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("stall_sent", 64'(sent), 64'd8);
        drain();

        // Asynchronous reset with bundles in flight.
        send(32'h1111_1111, 32'h2222_2222, 1'b0, 1'b0, {32'h3333_3333, 1'b0, 1'b0});
        send(32'h3333_3333, 32'h1111_1111, 1'b1, 1'b0, {32'h2222_2222, 1'b1, 1'b0});
        send(32'h4444_4444, 32'h4444_4444, 1'b0, 1'b0, {32'h8888_8888, 1'b0, 1'b1});
        send(32'h0000_0009, 32'h0000_0001, 1'b0, 1'b0, {32'h0000_000A, 1'b0, 1'b0});
        out_ready = 1'b0;
        #2;
        chk("pre_reset_valid", {63'd0, out_valid}, 64'd1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("mid_rst_ans",       {32'd0, ans},       64'd0);
        chk("mid_rst_in_ready",  {63'd0, in_ready},  64'd1);
        sb.delete();
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("post_rst_idle", {63'd0, out_valid}, 64'd0);
            @(posedge clk); #1;
        end

        // Random traffic with random backpressure.
        for (int c = 0; c < 5000; c++) begin
            out_ready = ($urandom_range(0, 3) != 0);
            in_valid  = $urandom_range(0, 1) == 1;
            case ($urandom_range(0, 7))
                0:       A = 32'h7FFF_FFFF;
                1:       A = 32'h8000_0000;
                2:       A = 32'hFFFF_FFFF;
                default: A = $urandom;
            endcase
            B   = ($urandom_range(0, 5) == 0) ? 32'h0000_0001 : $urandom;
            SUB = $urandom_range(0, 1) == 1;
            SAT = $urandom_range(0, 1) == 1;
            @(negedge clk);
            chk("rand_in_ready", {63'd0, in_ready}, {63'd0, (!out_valid || out_ready)});
            if (in_valid && in_ready) sb.push_back(model(A, B, SUB, SAT));
            @(posedge clk); #1;
        end
        drain();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
